// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the multicycle main FSM and the shared datapath.
// Optional MemReady handshake is present only when MEM_READY_EN is defined.
interface multicycle_ctrl_fsm_if;
    logic [6:0] op;
    logic       Zero;
`ifdef MEM_READY_EN
    logic       MemReady;
`endif
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] ImmSrc;
    logic       RegWrite;
    logic       Done;
    logic       Illegal;

`ifdef MEM_READY_EN
    modport master (
        input  op, Zero, MemReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUOp, ImmSrc, RegWrite, Done, Illegal
    );
    modport slave (
        output op, Zero, MemReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUOp, ImmSrc, RegWrite, Done, Illegal
    );
`else
    modport master (
        input  op, Zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUOp, ImmSrc, RegWrite, Done, Illegal
    );
    modport slave (
        output op, Zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUOp, ImmSrc, RegWrite, Done, Illegal
    );
`endif
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle RV32I core (lw, sw, R, I-ALU, beq, jal).
// Optional macro MEM_READY_EN: FETCH/MEMREAD/MEMWRITE wait on bus.MemReady.
module multicycle_ctrl_fsm (
    input  logic clk,
    input  logic reset,
    multicycle_ctrl_fsm_if.master bus
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECUTER, EXECUTEI, ALUWB, BEQ, JAL
    } state_t;

    typedef struct packed {
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       done;
        logic       branch;
        logic       pc_update;
        logic       decode;
    } ctrl_t;

    state_t state;
    state_t nxt;
    ctrl_t  ctl;
    logic   mem_ready;
    logic   known_op;
    logic   live;
    logic   pc_update;
    logic   illegal;

`ifdef MEM_READY_EN
    assign mem_ready = bus.MemReady;
`else
    assign mem_ready = 1'b1;
`endif

    // Moore output word for a given state; registered alongside the state.
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:    begin c.ir_write = 1'b1; c.alu_src_b = 2'b10;
                            c.result_src = 2'b10; c.pc_update = 1'b1; end
            DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; c.decode = 1'b1; end
            MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
            MEMREAD:  begin c.adr_src = 1'b1; end
            MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; c.done = 1'b1; end
            MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; c.done = 1'b1; end
            EXECUTER: begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
            EXECUTEI: begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
            ALUWB:    begin c.reg_write = 1'b1; c.done = 1'b1; end
            BEQ:      begin c.alu_src_a = 2'b10; c.alu_op = 2'b01;
                            c.branch = 1'b1; c.done = 1'b1; end
            JAL:      begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_update = 1'b1; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    assign known_op = (bus.op inside {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL});

    // Next-state selection; waiting states loop on themselves until memory is ready.
    always_comb begin
        nxt = FETCH;
        case (state)
            FETCH:    nxt = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_R:         nxt = EXECUTER;
                    OP_I:         nxt = EXECUTEI;
                    OP_BEQ:       nxt = BEQ;
                    OP_JAL:       nxt = JAL;
                    default:      nxt = FETCH;
                endcase
            end
            MEMADR:   nxt = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  nxt = mem_ready ? MEMWB : MEMREAD;
            MEMWB:    nxt = FETCH;
            MEMWRITE: nxt = mem_ready ? FETCH : MEMWRITE;
            EXECUTER: nxt = ALUWB;
            EXECUTEI: nxt = ALUWB;
            ALUWB:    nxt = FETCH;
            BEQ:      nxt = FETCH;
            JAL:      nxt = ALUWB;
            default:  nxt = FETCH;
        endcase
    end

    // State register with registered Moore outputs; reset loads FETCH selects.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            ctl   <= state_ctrl(FETCH);
        end else begin
            state <= nxt;
            ctl   <= state_ctrl(nxt);
        end
    end

    // Registered FETCH enables are preloaded during reset, so enables are
    // masked by reset here; unreachable encodings also mask every enable.
    assign live      = ~reset & (state <= JAL);
    assign pc_update = ctl.pc_update & (~ctl.ir_write | mem_ready);
    assign illegal   = live & ctl.decode & ~known_op;

    assign bus.PCWrite   = live & (pc_update | (ctl.branch & bus.Zero));
    assign bus.IRWrite   = live & ctl.ir_write & mem_ready;
    assign bus.MemWrite  = live & ctl.mem_write;
    assign bus.RegWrite  = live & ctl.reg_write;
    assign bus.Done      = (live & ctl.done & (~ctl.mem_write | mem_ready)) | illegal;
    assign bus.Illegal   = illegal;
    assign bus.AdrSrc    = ctl.adr_src;
    assign bus.ResultSrc = ctl.result_src;
    assign bus.ALUSrcA   = ctl.alu_src_a;
    assign bus.ALUSrcB   = ctl.alu_src_b;
    assign bus.ALUOp     = ctl.alu_op;

    // Immediate format follows the opcode directly.
    always_comb begin
        case (bus.op)
            OP_SW:   bus.ImmSrc = 2'b01;
            OP_BEQ:  bus.ImmSrc = 2'b10;
            OP_JAL:  bus.ImmSrc = 2'b11;
            default: bus.ImmSrc = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: directed instructions, a
// mid-instruction reset, then a random instruction stream checked per cycle
// against an instruction/cycle-number reference model.
module tb_multicycle_ctrl_fsm;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_JAL = 5, K_ILL = 6;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [16:0] obs;

    multicycle_ctrl_fsm_if bus ();

    multicycle_ctrl_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, RegWrite, Done, Illegal}
    assign obs = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
                  bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ImmSrc,
                  bus.RegWrite, bus.Done, bus.Illegal};

    function automatic logic [6:0] kind_op(input int kind);
        case (kind)
            K_LW:    return 7'b0000011;
            K_SW:    return 7'b0100011;
            K_R:     return 7'b0110011;
            K_I:     return 7'b0010011;
            K_BEQ:   return 7'b1100011;
            K_JAL:   return 7'b1101111;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic string kind_name(input int kind);
        case (kind)
            K_LW:    return "lw";
            K_SW:    return "sw";
            K_R:     return "rtype";
            K_I:     return "itype";
            K_BEQ:   return "beq";
            K_JAL:   return "jal";
            default: return "illegal";
        endcase
    endfunction

    function automatic int latency(input int kind);
        case (kind)
            K_LW:    return 5;
            K_BEQ:   return 3;
            K_ILL:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic is_legal(input logic [6:0] op);
        return op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
               op == 7'b0010011 || op == 7'b1100011 || op == 7'b1101111;
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] op);
        if (op == 7'b0100011) return 2'b01;
        if (op == 7'b1100011) return 2'b10;
        if (op == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    // Expected outputs for cycle k (1-based) of an instruction of the given kind.
    function automatic logic [16:0] model(input int kind, input int k,
                                          input logic [6:0] op, input logic z);
        logic pcw, adr, mw, irw, rw, dn, il;
        logic [1:0] rs, sa, sb, aop;
        {pcw, adr, mw, irw, rw, dn, il} = '0;
        {rs, sa, sb, aop} = '0;
        if (k == 1) begin
            pcw = 1'b1; irw = 1'b1; rs = 2'b10; sb = 2'b10;
        end else if (k == 2) begin
            sa = 2'b01; sb = 2'b01;
            if (kind == K_ILL) begin dn = 1'b1; il = 1'b1; end
        end else begin
            case (kind)
                K_LW: begin
                    if (k == 3) begin sa = 2'b10; sb = 2'b01; end
                    if (k == 4) adr = 1'b1;
                    if (k == 5) begin rs = 2'b01; rw = 1'b1; dn = 1'b1; end
                end
                K_SW: begin
                    if (k == 3) begin sa = 2'b10; sb = 2'b01; end
                    if (k == 4) begin adr = 1'b1; mw = 1'b1; dn = 1'b1; end
                end
                K_R, K_I: begin
                    if (k == 3) begin sa = 2'b10; aop = 2'b10; sb = (kind == K_I) ? 2'b01 : 2'b00; end
                    if (k == 4) begin rw = 1'b1; dn = 1'b1; end
                end
                K_BEQ: begin
                    sa = 2'b10; aop = 2'b01; dn = 1'b1; pcw = z;
                end
                K_JAL: begin
                    if (k == 3) begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
                    if (k == 4) begin rw = 1'b1; dn = 1'b1; end
                end
                default: ;
            endcase
        end
        return {pcw, adr, mw, irw, rs, sa, sb, aop, imm_of(op), rw, dn, il};
    endfunction

    // Under reset: no enables or pulses, FETCH select values.
    function automatic logic [16:0] reset_exp(input logic [6:0] op);
        return {1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, imm_of(op), 1'b0, 1'b0, 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    // Runs cycles 1..ncyc of one instruction; zmode 0/1 forces Zero, 2 randomizes.
    task automatic run_instr(input int kind, input logic [6:0] op, input int zmode, input int ncyc);
        for (int k = 1; k <= ncyc; k++) begin
            bus.op   = op;
            bus.Zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
            #1;
            chk($sformatf("%s op=%b cycle%0d", kind_name(kind), op, k), obs,
                model(kind, k, op, bus.Zero));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [6:0] op;
        int kind;
`ifdef MEM_READY_EN
        bus.MemReady = 1'b1;
`endif
        reset    = 1'b1;
        bus.op   = 7'b0100011;
        bus.Zero = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset idle", obs, reset_exp(bus.op));
        @(negedge clk);
        reset = 1'b0;

        run_instr(K_LW,  kind_op(K_LW),  2, 5);
        run_instr(K_SW,  kind_op(K_SW),  2, 4);
        run_instr(K_BEQ, kind_op(K_BEQ), 1, 3);
        run_instr(K_BEQ, kind_op(K_BEQ), 0, 3);
        run_instr(K_R,   kind_op(K_R),   2, 4);
        run_instr(K_I,   kind_op(K_I),   2, 4);
        run_instr(K_JAL, kind_op(K_JAL), 2, 4);
        run_instr(K_ILL, 7'b1111111,     2, 2);
        run_instr(K_ILL, 7'b0000000,     2, 2);

        // Abandon a load in MEMREAD.
        run_instr(K_LW, kind_op(K_LW), 2, 3);
        #1;
        reset = 1'b1;
        #1;
        chk("reset during MEMREAD", obs, reset_exp(kind_op(K_LW)));
        @(negedge clk);
        reset = 1'b0;
        run_instr(K_SW, kind_op(K_SW), 2, 4);

        for (int n = 0; n < 80; n++) begin
            kind = int'($urandom_range(0, 6));
            if (kind == K_ILL) begin
                op = 7'($urandom);
                while (is_legal(op)) op = 7'($urandom);
            end else begin
                op = kind_op(kind);
            end
            run_instr(kind, op, 2, latency(kind));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
